shift_sequencer: RTL and testbench

- Controller that loads a parallel word into the team's N-bit serial shift register, one bit per enable pulse.
- Accepts a word plus a direction over a valid/ready handshake.
- Drives the register's enable, direction and serial-data inputs for exactly WIDTH shifts, with optional idle gaps between bits.
- Pulses done when the register holds the word in its original bit order.

---
 rtl/shift_sequencer_if.sv | 30 +++
 rtl/shift_sequencer.sv | 86 ++++++++
 tb/tb_shift_sequencer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_sequencer_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | shift_sequencer_if : word handshake plus shift-register controls |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface shift_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] in_word_i;
  logic             in_dir_i;
  logic             abort_i;
  logic             sr_en_o;
  logic             sr_dir_o;
  logic             sr_data_o;
  logic             busy_o;
  logic             done_o;

  modport slave (
    input  in_valid_i, in_word_i, in_dir_i, abort_i,
    output in_ready_o, sr_en_o, sr_dir_o, sr_data_o, busy_o, done_o
  );

  modport master (
    output in_valid_i, in_word_i, in_dir_i, abort_i,
    input  in_ready_o, sr_en_o, sr_dir_o, sr_data_o, busy_o, done_o
  );
endinterface
`default_nettype wire

// File: rtl/shift_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | shift_sequencer : serialises a word into a WIDTH-bit shift reg   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module shift_sequencer #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 0
) (
  input  wire logic        clk_i,
  input  wire logic        rstn_i,
  shift_sequencer_if.slave bus
);
  localparam int c_BIT_W = $clog2(WIDTH);
  localparam int c_GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(WIDTH - 1);
  localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_SHIFT = 2'd1;
  localparam logic [1:0] c_GAP   = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  logic [1:0]         r_state;
  logic [WIDTH-1:0]   r_word;
  logic               r_dir;
  logic [c_BIT_W-1:0] r_bit_cnt;
  logic [c_GAP_W-1:0] r_gap_cnt;
  logic [c_BIT_W-1:0] w_bit_idx;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state   <= c_IDLE;
      r_word    <= '0;
      r_dir     <= 1'b0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (bus.in_valid_i) begin
            r_word    <= bus.in_word_i;
            r_dir     <= bus.in_dir_i;
            r_bit_cnt <= '0;
            r_state   <= c_SHIFT;
          end
        end
        c_SHIFT: begin
          if (bus.abort_i) begin
            r_state <= c_IDLE;
          end else if (r_bit_cnt == c_BIT_LAST) begin
            r_state <= c_DONE;
          end else begin
            r_bit_cnt <= r_bit_cnt + c_BIT_W'(1);
            if (GAP_CYCLES > 0) begin
              r_gap_cnt <= '0;
              r_state   <= c_GAP;
            end
          end
        end
        c_GAP: begin
          if (bus.abort_i) begin
            r_state <= c_IDLE;
          end else if (r_gap_cnt == c_GAP_LAST) begin
            r_state <= c_SHIFT;
          end else begin
            r_gap_cnt <= r_gap_cnt + c_GAP_W'(1);
          end
        end
        c_DONE:  r_state <= c_IDLE;
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // Left shifts send MSB first, right shifts LSB first, so the word lands in original order.
  assign w_bit_idx = r_dir ? r_bit_cnt : (c_BIT_LAST - r_bit_cnt);

  assign bus.in_ready_o = (r_state == c_IDLE);
  assign bus.sr_en_o    = (r_state == c_SHIFT);
  assign bus.sr_dir_o   = r_dir;
  assign bus.sr_data_o  = (r_state == c_SHIFT) & r_word[w_bit_idx];
  assign bus.busy_o     = (r_state != c_IDLE);
  assign bus.done_o     = (r_state == c_DONE);
endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_shift_sequencer : two lanes (GAP 0 and GAP 2) with scoreboard |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_shift_sequencer;
  localparam int W   = 8;
  localparam int NTX = 40;

  typedef struct {
    int         acc;
    int         endc;
    int         nsh;
    logic [7:0] word;
    logic       dir;
    bit         full;
    bit         rst;
  } item_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   lanes_done = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input int lane, input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL lane%0d %s @cycle %0d: got %0d expected %0d", lane, name, cyc, act, exp);
    end
  endtask

  task automatic finish_lane();
    lanes_done++;
  endtask

  // Directed cases first: mode 0 normal, 1 abort at rel p, 2 reset at rel p, 3 abort in DONE, 4 hold valid
  function automatic void directed(input int t, output logic [7:0] w, output logic d,
                                   output int mode, output int p);
    p = 0;
    case (t)
      0:       begin w = 8'hA5; d = 1'b0; mode = 0; end
      1:       begin w = 8'hC4; d = 1'b1; mode = 0; end
      2:       begin w = 8'h0F; d = 1'b0; mode = 0; end
      3:       begin w = 8'h5A; d = 1'b0; mode = 1; p = 4; end
      4:       begin w = 8'h3C; d = 1'b1; mode = 2; p = 3; end
      5:       begin w = 8'h12; d = 1'b0; mode = 4; end
      default: begin w = 8'h34; d = 1'b0; mode = 0; end
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int G        = g * 2;
    localparam int DONE_REL = (W - 1) * (G + 1) + 2;
    localparam int SPAN     = (W - 1) * (G + 1) + 1;

    logic  rstn;
    bit    started = 1'b0;
    item_t q[$];

    shift_sequencer_if #(.WIDTH(W)) bus ();

    shift_sequencer #(.WIDTH(W), .GAP_CYCLES(G)) u_dut (
      .clk_i  (clk),
      .rstn_i (rstn),
      .bus    (bus)
    );

    initial begin : drv
      item_t      it;
      logic [7:0] w;
      logic       d;
      int         mode, p, k, acc, prev_acc;
      bit         prev_hold;
      rstn = 1'b0;
      bus.in_valid_i = 1'b0;
      bus.in_word_i  = '0;
      bus.in_dir_i   = 1'b0;
      bus.abort_i    = 1'b0;
      prev_hold = 1'b0;
      prev_acc  = 0;
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      started = 1'b1;
      for (int t = 0; t < NTX; t++) begin
        if (t < 7) begin
          directed(t, w, d, mode, p);
        end else begin
          w    = 8'($urandom);
          d    = 1'($urandom);
          mode = $urandom_range(0, 4);
          if (t == NTX - 1 && mode == 4) mode = 0;
          p    = $urandom_range(1, SPAN);
        end
        if (mode == 3) p = DONE_REL;
        if (!prev_hold) begin
          k = 0;
          @(negedge clk);
          while (!bus.in_ready_o && k < 200) begin
            @(negedge clk);
            k++;
          end
          if (k >= 200) chk(g, "idle_timeout", 0, 1);
          @(posedge clk);
          #1;
          // abort while idle must be ignored
          repeat ($urandom_range(0, 2)) begin
            bus.abort_i = 1'($urandom);
            @(posedge clk);
            #1;
          end
          bus.abort_i = 1'($urandom);
        end
        bus.in_valid_i = 1'b1;
        bus.in_word_i  = w;
        bus.in_dir_i   = d;
        k = 0;
        @(negedge clk);
        while (!bus.in_ready_o && k < 200) begin
          @(negedge clk);
          k++;
        end
        if (k >= 200) chk(g, "accept_timeout", 0, 1);
        acc = cyc;
        @(posedge clk);
        #1;
        bus.abort_i = 1'b0;
        if (mode != 4) begin
          bus.in_valid_i = 1'b0;
          bus.in_word_i  = 8'($urandom);
          bus.in_dir_i   = 1'($urandom);
        end
        it.acc  = acc;
        it.word = w;
        it.dir  = d;
        it.full = 1'b1;
        it.rst  = 1'b0;
        it.nsh  = W;
        it.endc = acc + DONE_REL;
        if (mode == 1 || mode == 2) begin
          it.full = 1'b0;
          it.rst  = (mode == 2);
          it.nsh  = (p - 1) / (G + 1) + 1;
          it.endc = acc + p;
        end
        q.push_back(it);
        if (prev_hold) chk(g, "b2b_accept_cycle", acc, prev_acc + DONE_REL + 1);
        if (mode == 1 || mode == 2 || mode == 3) begin
          repeat (p - 1) @(posedge clk);
          #1;
          if (mode == 2) rstn = 1'b0;
          else bus.abort_i = 1'b1;
          @(posedge clk);
          #1;
          rstn = 1'b1;
          bus.abort_i = 1'b0;
        end
        prev_hold = (mode == 4);
        prev_acc  = acc;
      end
      k = 0;
      while (q.size() != 0 && k < 500) begin
        @(posedge clk);
        k++;
      end
      if (q.size() != 0) chk(g, "drain_timeout", q.size(), 0);
      finish_lane();
    end

    initial begin : mon
      item_t      h;
      logic [7:0] sreg;
      logic [7:0] e;
      logic       last_dir;
      logic       eb;
      int         rel, j;
      bit         exp_en;
      sreg     = '0;
      last_dir = 1'b0;
      forever begin
        @(negedge clk);
        if (started) begin
          if (q.size() != 0 && cyc > q[0].acc && cyc <= q[0].endc) begin
            h      = q[0];
            rel    = cyc - h.acc - 1;
            j      = rel / (G + 1);
            exp_en = (rel % (G + 1) == 0) && (j < h.nsh);
            chk(g, "sr_en", bus.sr_en_o, exp_en);
            chk(g, "busy", bus.busy_o, 1);
            chk(g, "in_ready", bus.in_ready_o, 0);
            chk(g, "done", bus.done_o, h.full && cyc == h.endc);
            chk(g, "sr_dir", bus.sr_dir_o, h.dir);
            if (exp_en) begin
              eb = h.dir ? h.word[j] : h.word[W-1-j];
              chk(g, "sr_data", bus.sr_data_o, eb);
            end else begin
              chk(g, "sr_data_idle", bus.sr_data_o, 0);
            end
          end else begin
            if (q.size() != 0 && cyc == q[0].endc + 1) begin
              h = q[0];
              if (h.full)      e = h.word;
              else if (h.dir)  e = h.word << (W - h.nsh);
              else             e = h.word >> (W - h.nsh);
              chk(g, h.full ? "reg_full" : "reg_partial", sreg, e);
              last_dir = h.rst ? 1'b0 : h.dir;
              void'(q.pop_front());
              sreg = '0;
            end
            chk(g, "idle_ready", bus.in_ready_o, 1);
            chk(g, "idle_busy", bus.busy_o, 0);
            chk(g, "idle_en", bus.sr_en_o, 0);
            chk(g, "idle_done", bus.done_o, 0);
            chk(g, "idle_data", bus.sr_data_o, 0);
            chk(g, "idle_dir", bus.sr_dir_o, last_dir);
          end
          // Behaviour of the external shift register fed by the sequencer
          if (bus.sr_en_o === 1'b1) begin
            if (bus.sr_dir_o) sreg = {bus.sr_data_o, sreg[7:1]};
            else              sreg = {sreg[6:0], bus.sr_data_o};
          end
        end
      end
    end
  end

  initial begin : top
    int k;
    k = 0;
    while (lanes_done < 2 && k < 60000) begin
      @(posedge clk);
      k++;
    end
    if (lanes_done < 2) chk(0, "global_timeout", lanes_done, 2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
